// File: rtl/layer3_mac_sink.sv
// layer3_mac_sink: LANES-wide MAC array with ReLU/requantisation and a two-half
// frame assembler that hands 2*LANES results downstream over valid/ready.
module layer3_mac_sink #(
  parameter int LANES  = 32,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 7
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        mac_en_i,
  input  logic                        mac_clear_i,
  input  logic                        relu_en_i,
  input  logic                        temp_wr_en_i,
  input  logic                        temp_wr_en_1_i,
  input  logic [LANES*DATA_W-1:0]     w_data_i,
  input  logic [DATA_W-1:0]           x_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [2*LANES*DATA_W-1:0]   out_data_o,
  output logic [7:0]                  frame_cnt_o,
  output logic                        overrun_o,
  output logic                        seq_err_o
);

  // state | meaning
  // EMPTY | nothing captured for the current frame
  // HALF  | half 0 held in bank0, waiting for half 1
  // FULL  | frame presented on out_data_o, waiting for the handshake
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int HALF_W = LANES * DATA_W;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] RELU_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);

  logic signed [PROD_W-1:0] prod     [LANES];
  logic signed [ACC_W-1:0]  prod_ext [LANES];
  logic signed [ACC_W-1:0]  shifted  [LANES];
  logic signed [ACC_W-1:0]  acc_q    [LANES];
  logic signed [ACC_W-1:0]  acc_d    [LANES];

  logic [HALF_W-1:0]   relu_q, relu_d;
  logic [HALF_W-1:0]   bank0_q, bank0_d;
  logic [2*HALF_W-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                overrun_q, overrun_d;
  logic                seq_err_q, seq_err_d;
  state_t              state_q, state_d;
  logic                handshake;

  always_comb begin
    relu_d = relu_q;
    for (int k = 0; k < LANES; k++) begin
      prod[k]     = $signed(w_data_i[k*DATA_W +: DATA_W]) * $signed(x_data_i);
      prod_ext[k] = {{(ACC_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};

      if (mac_en_i && mac_clear_i) begin
        acc_d[k] = prod_ext[k];
      end else if (mac_en_i) begin
        acc_d[k] = acc_q[k] + prod_ext[k];
      end else if (mac_clear_i) begin
        acc_d[k] = '0;
      end else begin
        acc_d[k] = acc_q[k];
      end

      shifted[k] = acc_q[k] >>> SHIFT;
      if (relu_en_i) begin
        if (acc_q[k][ACC_W-1]) begin
          relu_d[k*DATA_W +: DATA_W] = '0;
        end else if (shifted[k] > RELU_MAX) begin
          relu_d[k*DATA_W +: DATA_W] = RELU_MAX[DATA_W-1:0];
        end else begin
          relu_d[k*DATA_W +: DATA_W] = shifted[k][DATA_W-1:0];
        end
      end
    end
  end

  // The half-1 bank is the upper half of out_data_q: it is only ever
  // written together with the frame launch, so a separate copy is redundant.
  always_comb begin
    state_d     = state_q;
    bank0_d     = bank0_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    seq_err_d   = seq_err_q;
    handshake   = out_valid_q && out_ready_i;

    case (state_q)
      EMPTY: begin
        if (temp_wr_en_1_i) begin
          seq_err_d = 1'b1;
        end else if (temp_wr_en_i) begin
          bank0_d = relu_q;
          state_d = HALF;
        end
      end
      HALF: begin
        if (temp_wr_en_1_i) begin
          out_data_d  = {relu_q, bank0_q};
          out_valid_d = 1'b1;
          state_d     = FULL;
        end else if (temp_wr_en_i) begin
          bank0_d = relu_q;
        end
      end
      FULL: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = EMPTY;
          // a half-1 write here has no half 0 behind it in the new frame
          if (temp_wr_en_1_i) begin
            seq_err_d = 1'b1;
          end else if (temp_wr_en_i) begin
            bank0_d = relu_q;
            state_d = HALF;
          end
        end else if (temp_wr_en_i || temp_wr_en_1_i) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= '0;
      end
      relu_q      <= '0;
      bank0_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= 8'd0;
      overrun_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      state_q     <= EMPTY;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= acc_d[k];
      end
      relu_q      <= relu_d;
      bank0_q     <= bank0_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      seq_err_q   <= seq_err_d;
      state_q     <= state_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign frame_cnt_o = frame_cnt_q;
  assign overrun_o   = overrun_q;
  assign seq_err_o   = seq_err_q;

endmodule

// File: tb/tb_layer3_mac_sink.sv
// Scoreboard bench for layer3_mac_sink: directed MAC/ReLU vectors with
// hand-computed frames, checked by a monitor on each output handshake.
module tb_layer3_mac_sink;
  localparam int LANES  = 32;
  localparam int DATA_W = 8;
  localparam int HW     = LANES * DATA_W;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            mac_en_i, mac_clear_i, relu_en_i, temp_wr_en_i, temp_wr_en_1_i;
  logic [HW-1:0]   w_data_i;
  logic [DATA_W-1:0] x_data_i;
  logic            out_valid_o, out_ready_i;
  logic [2*HW-1:0] out_data_o;
  logic [7:0]      frame_cnt_o;
  logic            overrun_o, seq_err_o;

  typedef struct {
    logic [2*HW-1:0] data;
    logic [7:0]      cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  layer3_mac_sink #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(24), .SHIFT(7)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .mac_en_i       (mac_en_i),
    .mac_clear_i    (mac_clear_i),
    .relu_en_i      (relu_en_i),
    .temp_wr_en_i   (temp_wr_en_i),
    .temp_wr_en_1_i (temp_wr_en_1_i),
    .w_data_i       (w_data_i),
    .x_data_i       (x_data_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .frame_cnt_o    (frame_cnt_o),
    .overrun_o      (overrun_o),
    .seq_err_o      (seq_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [2*HW-1:0] act, input logic [2*HW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %0h expected no frame", out_data_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("frame_data", out_data_o, mon_e.data);
        chk("frame_cnt_at_hs", frame_cnt_o, mon_e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [HW-1:0] set_lane(input logic [HW-1:0] v, input int k, input logic [7:0] b);
    logic [HW-1:0] r;
    r = v;
    r[k*DATA_W +: DATA_W] = b;
    return r;
  endfunction

  // n MAC cycles (first with clear) followed by a ReLU strobe
  task automatic load_relu(input logic [HW-1:0] w, input logic [7:0] x, input int n);
    w_data_i    = w;
    x_data_i    = x;
    mac_en_i    = 1'b1;
    mac_clear_i = 1'b1;
    tick();
    mac_clear_i = 1'b0;
    repeat (n - 1) tick();
    mac_en_i  = 1'b0;
    relu_en_i = 1'b1;
    tick();
    relu_en_i = 1'b0;
  endtask

  task automatic wr0();
    temp_wr_en_i = 1'b1;
    tick();
    temp_wr_en_i = 1'b0;
  endtask

  task automatic wr1();
    temp_wr_en_1_i = 1'b1;
    tick();
    temp_wr_en_1_i = 1'b0;
  endtask

  task automatic push(input logic [2*HW-1:0] d, input logic [7:0] c);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk(name, sb_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, out_valid_o, 1'b0);
    chk({tag, "_data"}, out_data_o, '0);
    chk({tag, "_cnt"}, frame_cnt_o, 8'd0);
    chk({tag, "_overrun"}, overrun_o, 1'b0);
    chk({tag, "_seq_err"}, seq_err_o, 1'b0);
  endtask

  logic [HW-1:0] wa, wb, wc, ea, eb, ec, v0, v1, pa0, pa1, pb0, p4, p5;

  initial begin
    rst_i = 1'b1;
    mac_en_i = 1'b0; mac_clear_i = 1'b0; relu_en_i = 1'b0;
    temp_wr_en_i = 1'b0; temp_wr_en_1_i = 1'b0;
    w_data_i = '0; x_data_i = '0; out_ready_i = 1'b0;
    repeat (2) tick();
    check_reset_state("reset");
    rst_i = 1'b0;
    out_ready_i = 1'b1;

    // run A, x=3: lane0 2*3*64=384 -> 3; lane3 40*3*64=7680 -> 60
    wa = '0; wa = set_lane(wa, 0, 8'd2); wa = set_lane(wa, 3, 8'd40);
    ea = '0; ea = set_lane(ea, 0, 8'd3); ea = set_lane(ea, 3, 8'd60);
    // run B, x=5: lane1 -320 -> 0; lane4 32000 -> 250 -> 127; lane6 320 -> 2
    wb = '0; wb = set_lane(wb, 1, 8'hFF); wb = set_lane(wb, 4, 8'd100); wb = set_lane(wb, 6, 8'd1);
    eb = '0; eb = set_lane(eb, 4, 8'd127); eb = set_lane(eb, 6, 8'd2);
    // run C, x=127: lane2 1032256 -> 127; lane5 negative -> 0; lane7 8128 -> 63; lane8 -8128 -> 0
    wc = '0; wc = set_lane(wc, 2, 8'd127); wc = set_lane(wc, 5, 8'h80);
    wc = set_lane(wc, 7, 8'd1); wc = set_lane(wc, 8, 8'hFF);
    ec = '0; ec = set_lane(ec, 2, 8'd127); ec = set_lane(ec, 7, 8'd63);

    load_relu(wa, 8'd3, 64);
    wr0();
    load_relu(wb, 8'd5, 64);
    push({eb, ea}, 8'd0);
    wr1();
    chk("valid_rises", out_valid_o, 1'b1);
    tick();
    chk("valid_one_cycle", out_valid_o, 1'b0);
    chk("cnt_after_f1", frame_cnt_o, 8'd1);

    // relu_q holds between strobes, so both halves carry run C
    load_relu(wc, 8'd127, 64);
    wr0();
    push({ec, ec}, 8'd1);
    wr1();
    tick();
    chk("cnt_after_f2", frame_cnt_o, 8'd2);

    // byte j of the frame equals j: w=k, x=64, two terms -> 128*k >>> 7 = k
    v0 = '0; v1 = '0;
    for (int k = 0; k < LANES; k++) begin
      v0 = set_lane(v0, k, 8'(k));
      v1 = set_lane(v1, k, 8'(k + 32));
    end
    load_relu(v0, 8'd64, 2);
    wr0();
    load_relu(v1, 8'd64, 2);
    push({v1, v0}, 8'd2);
    wr1();
    tick();
    chk("cnt_after_f3", frame_cnt_o, 8'd3);

    // back-pressure
    out_ready_i = 1'b0;
    pa0 = '0; pa1 = '0; pb0 = '0;
    for (int k = 0; k < LANES; k++) begin
      pa0 = set_lane(pa0, k, 8'((k * 3) % 64));
      pa1 = set_lane(pa1, k, 8'(63 - k));
      pb0 = set_lane(pb0, k, 8'((k + 5) % 64));
    end
    load_relu(pa0, 8'd64, 2);
    wr0();
    load_relu(pa1, 8'd64, 2);
    push({pa1, pa0}, 8'd3);
    wr1();
    repeat (3) tick();
    chk("bp_valid_held", out_valid_o, 1'b1);
    chk("bp_overrun_clear", overrun_o, 1'b0);
    load_relu(pb0, 8'd64, 2);
    wr0();
    chk("bp_overrun_set", overrun_o, 1'b1);
    chk("bp_valid_still", out_valid_o, 1'b1);
    chk("bp_data_stable", out_data_o, {pa1, pa0});
    chk("bp_seq_err_clear", seq_err_o, 1'b0);
    out_ready_i = 1'b1;
    tick();
    chk("bp_valid_drop", out_valid_o, 1'b0);
    chk("bp_cnt", frame_cnt_o, 8'd4);
    wr1();
    chk("bp_empty_seq_err", seq_err_o, 1'b1);
    chk("bp_empty_no_valid", out_valid_o, 1'b0);
    wait_drain("drain_1");

    // reset in cycle 30 of an accumulation
    w_data_i = '0;
    for (int k = 0; k < LANES; k++) w_data_i = set_lane(w_data_i, k, 8'd50);
    x_data_i = 8'd100;
    mac_en_i = 1'b1;
    mac_clear_i = 1'b1;
    tick();
    mac_clear_i = 1'b0;
    repeat (28) tick();
    mac_en_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset_state("midreset");

    wr1();
    chk("seq_err_after_reset", seq_err_o, 1'b1);
    chk("no_valid_after_seq_err", out_valid_o, 1'b0);

    // accumulators were cleared: relu without MAC yields an all-zero frame
    out_ready_i = 1'b0;
    relu_en_i = 1'b1;
    tick();
    relu_en_i = 1'b0;
    wr0();
    push('0, 8'd0);
    wr1();
    chk("zero_frame_valid", out_valid_o, 1'b1);

    // handshake and a new half 0 in the same cycle
    p4 = '0; p5 = '0;
    for (int k = 0; k < LANES; k++) begin
      p4 = set_lane(p4, k, 8'((k * 7) % 64));
      p5 = set_lane(p5, k, 8'((k * 11 + 1) % 64));
    end
    load_relu(p4, 8'd64, 2);
    out_ready_i = 1'b1;
    wr0();
    chk("hs_wr0_valid", out_valid_o, 1'b0);
    chk("hs_wr0_cnt", frame_cnt_o, 8'd1);
    chk("hs_wr0_no_overrun", overrun_o, 1'b0);
    load_relu(p5, 8'd64, 2);
    push({p5, p4}, 8'd1);
    wr1();
    tick();
    chk("final_cnt", frame_cnt_o, 8'd2);
    wait_drain("drain_2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer3_mac_sink.md
Name: layer3_mac_sink

Overview:
- Datapath responder for the layer-3 local controller. Consumes its mac_en / mac_clear / relu_en / temp_wr_en / temp_wr_en_1 strobes together with weight and activation words read from the layer-3 buffers.
- Runs LANES parallel MAC lanes, applies ReLU and requantisation, and collects the two 32-neuron halves into a 64-result frame.
- Hands each complete frame to the next layer over a valid/ready interface.

Parameters:
- LANES, 32, neurons per half (MAC lanes); frame = 2*LANES results
- DATA_W, 8, signed weight/activation width and result width
- ACC_W, 24, signed accumulator width
- SHIFT, 7, arithmetic right shift applied at requantisation

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mac_en_i  in  1  accumulate strobe; w_data_i/x_data_i valid this cycle
- mac_clear_i  in  1  start new accumulation
- relu_en_i  in  1  one-cycle ReLU/requant strobe
- temp_wr_en_i  in  1  capture ReLU results into half-0 bank
- temp_wr_en_1_i  in  1  capture ReLU results into half-1 bank, completing the frame
- w_data_i  in  LANES*DATA_W  signed weights, lane k at bits [k*DATA_W +: DATA_W]
- x_data_i  in  DATA_W  signed activation shared by all lanes
- out_valid_o  out  1  frame available
- out_ready_i  in  1  downstream accepts frame
- out_data_o  out  2*LANES*DATA_W  frame; half 0 in the low LANES*DATA_W bits
- frame_cnt_o  out  8  delivered-frame count, wraps 255->0
- overrun_o  out  1  sticky: write dropped because frame buffer full
- seq_err_o  out  1  sticky: temp_wr_en_1 without a preceding half 0

Behaviour:
- Reset is synchronous and active-high on clk_i. It clears acc[], relu_q[], both banks, out_data_o, out_valid_o, frame_cnt_o, overrun_o and seq_err_o to 0, and sets the FSM to EMPTY. Reset mid-frame discards all partial data.
- MAC, per lane, registered:
  - mac_en=1, mac_clear=1 -> acc = w*x
  - mac_en=1, mac_clear=0 -> acc = acc + w*x
  - mac_en=0, mac_clear=1 -> acc = 0
  - otherwise acc holds
- Product is signed 2*DATA_W bits, sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W with no saturation (64 terms of 8x8 cannot overflow 24 bits).
- ReLU/requant: on relu_en_i, relu_q[k] <= (acc[k] < 0) ? 0 : min(acc[k] >>> SHIFT, 2^(DATA_W-1)-1). relu_q holds otherwise.
- Latency: relu_q reflects acc as registered in the cycle before relu_en_i. The controller already delays its strobes so that temp_wr_en follows relu_en by ≥1 cycle.
- Frame FSM states: EMPTY, HALF, FULL.
  - EMPTY: temp_wr_en -> bank0 <= relu_q, go HALF. temp_wr_en_1 -> ignored, seq_err_o <= 1.
  - HALF: temp_wr_en -> bank0 overwritten, stay HALF. temp_wr_en_1 -> bank1 <= relu_q, out_data_o <= {relu_q, bank0}, out_valid_o <= 1, go FULL.
  - FULL: out_valid_o=1. Handshake (out_valid_o & out_ready_i) -> out_valid_o <= 0, frame_cnt_o++, go EMPTY.
- Simultaneous events in FULL:
  - Handshake and temp_wr_en in the same cycle: the write is accepted, go HALF.
  - temp_wr_en or temp_wr_en_1 without handshake: write dropped, overrun_o <= 1, stay FULL, out_data_o stable.
  - temp_wr_en_1 with handshake: treated as seq error, since half 0 of the new frame is missing.
- temp_wr_en and temp_wr_en_1 asserted together: temp_wr_en_1 wins and temp_wr_en is ignored.
- out_data_o changes only on entry to FULL. While out_valid_o=1 and not accepted, out_data_o is held constant.
- Sticky flags clear only on reset.
- MAC strobes are independent of FSM state, so accumulation of the next half proceeds while FULL.

Test Plan:
- Single lane check: lane0 w=2, x=3 for 64 mac_en cycles, first with mac_clear -> acc=384; relu_en -> relu_q=min(384>>>7,127)=3.
- Negative and saturating: lane1 w=-1, x=5 x64 -> acc=-320 -> relu_q=0; lane2 w=127, x=127 x64 -> acc=1032256 -> relu_q=127.
- Full frame, out_ready_i=1: half0 lanes=k, half1 lanes=k+32 -> out_valid_o pulses 1 cycle, out_data_o byte j=j for j=0..63, frame_cnt_o=1.
- Back-pressure: out_ready_i=0, second frame's temp_wr_en arrives -> overrun_o=1, out_data_o unchanged. Then ready=1 -> frame_cnt_o increments and FSM goes EMPTY.
- Sequence errors: temp_wr_en_1 after reset -> seq_err_o=1, out_valid_o=0. Handshake plus temp_wr_en in the same cycle -> state HALF with the new bank0.
- Reset mid-accumulation (cycle 30 of 64) -> all outputs 0 next cycle; a following clean frame produces the correct results.
